// File: rtl/hd44780_nybbler_if.sv
// Write-request bus between the controller stage and the HD44780 nybbler.
// The controller drives the request; the nybbler returns busy and completion.
interface hd44780_nybbler_if;
  logic       STB_I;
  logic [9:0] DAT_I;
  logic       STB_O;
  logic       BUSY_O;

  modport master (
    output STB_I,
    output DAT_I,
    input  STB_O,
    input  BUSY_O
  );

  modport slave (
    input  STB_I,
    input  DAT_I,
    output STB_O,
    output BUSY_O
  );
endinterface

// File: rtl/hd44780_nybbler.sv
// 4-bit HD44780 write driver: splits a byte into nibbles, produces RS/E/DB timing
// with setup, pulse, gap and execution waits, then signals completion for one cycle.
module hd44780_nybbler #(
  parameter int SETUP_CYCLES      = 3,
  parameter int EPULSE_CYCLES     = 24,
  parameter int GAP_CYCLES        = 48,
  parameter int CMD_WAIT_CYCLES   = 1920,
  parameter int CLEAR_WAIT_CYCLES = 76800,
  parameter int ALIVE_BITS        = 23
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  hd44780_nybbler_if.slave  bus,
  output logic              o_lcd_rs,
  output logic              o_lcd_rw,
  output logic              o_lcd_e,
  output logic [3:0]        o_lcd_d,
  output logic              o_alive
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP_HI,
    S_EHIGH_HI,
    S_GAP,
    S_SETUP_LO,
    S_EHIGH_LO,
    S_WAIT,
    S_DONE
  } state_t;

  // The down-counter reaches zero on the last cycle of a state, so it is loaded
  // with count-1; a zero parameter is treated as one cycle.
  function automatic logic [16:0] reload(input int n);
    if (n <= 1) return 17'd0;
    return 17'(n - 1);
  endfunction

  localparam logic [16:0] L_SETUP  = reload(SETUP_CYCLES);
  localparam logic [16:0] L_EPULSE = reload(EPULSE_CYCLES);
  localparam logic [16:0] L_GAP    = reload(GAP_CYCLES);
  localparam logic [16:0] L_CMD    = reload(CMD_WAIT_CYCLES);
  localparam logic [16:0] L_CLEAR  = reload(CLEAR_WAIT_CYCLES);

  state_t                  r_state, w_state_nxt;
  logic [16:0]             r_cnt, w_cnt_nxt;
  logic                    r_single, w_single_nxt;
  logic                    r_clear, w_clear_nxt;
  logic [3:0]              r_lo, w_lo_nxt;
  logic                    r_rs, w_rs_nxt;
  logic [3:0]              r_d, w_d_nxt;
  logic                    r_e;
  logic                    r_busy;
  logic                    r_stb;
  logic [ALIVE_BITS-1:0]   r_alive;

  logic                    w_cnt_zero;
  logic                    w_is_clear;
  logic [16:0]             w_wait;

  assign w_cnt_zero = (r_cnt == 17'd0);
  assign w_wait     = r_clear ? L_CLEAR : L_CMD;
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign w_is_clear = !bus.DAT_I[9] && (bus.DAT_I[7:0] inside {8'h01, 8'h02, 8'h03});

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_single_nxt = r_single;
    w_clear_nxt  = r_clear;
    w_lo_nxt     = r_lo;
    w_rs_nxt     = r_rs;
    w_d_nxt      = r_d;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 17'd0;
        if (bus.STB_I) begin
          w_state_nxt  = S_SETUP_HI;
          w_cnt_nxt    = L_SETUP;
          w_single_nxt = bus.DAT_I[8];
          w_clear_nxt  = w_is_clear;
          w_lo_nxt     = bus.DAT_I[3:0];
          w_rs_nxt     = bus.DAT_I[9];
          w_d_nxt      = bus.DAT_I[7:4];
        end
      end
      S_SETUP_HI: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_EHIGH_HI;
          w_cnt_nxt   = L_EPULSE;
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_EHIGH_HI: begin
        if (w_cnt_zero) begin
          if (r_single) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_wait;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = L_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SETUP_LO;
          w_cnt_nxt   = L_SETUP;
          w_d_nxt     = r_lo;
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_SETUP_LO: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_EHIGH_LO;
          w_cnt_nxt   = L_EPULSE;
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_EHIGH_LO: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_wait;
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 17'd0;
        end else begin
          w_cnt_nxt = r_cnt - 17'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 17'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 17'd0;
      end
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= S_IDLE;
      r_cnt    <= 17'd0;
      r_single <= 1'b0;
      r_clear  <= 1'b0;
      r_lo     <= 4'd0;
      r_rs     <= 1'b0;
      r_d      <= 4'd0;
      r_e      <= 1'b0;
      r_busy   <= 1'b0;
      r_stb    <= 1'b0;
      r_alive  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_single <= w_single_nxt;
      r_clear  <= w_clear_nxt;
      r_lo     <= w_lo_nxt;
      r_rs     <= w_rs_nxt;
      r_d      <= w_d_nxt;
      // Registered decodes of the next state keep E/BUSY/STB aligned with it.
      r_e      <= (w_state_nxt == S_EHIGH_HI) || (w_state_nxt == S_EHIGH_LO);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_stb    <= (w_state_nxt == S_DONE);
      r_alive  <= r_alive + ALIVE_BITS'(1);
    end
  end

  assign bus.STB_O  = r_stb;
  assign bus.BUSY_O = r_busy;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_e    = r_e;
  assign o_lcd_d    = r_d;
  assign o_alive    = r_alive[ALIVE_BITS-1];

endmodule

// File: tb/tb_hd44780_nybbler.sv
// Self-checking bench for hd44780_nybbler: per-cycle comparison of the LCD
// waveform and handshake against a timing model built from the write rules.
module tb_hd44780_nybbler;

  localparam int S     = 2;
  localparam int P     = 3;
  localparam int G     = 4;
  localparam int CMD   = 10;
  localparam int CLEAR = 20;
  localparam int AB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs, lcd_rw, lcd_e, alive;
  logic [3:0] lcd_d;

  int errors = 0;
  int checks = 0;

  // Reference state held by the bench between writes.
  int         alive_m = 0;
  logic       last_rs = 1'b0;
  logic [3:0] last_d  = 4'd0;

  hd44780_nybbler_if bus ();

  hd44780_nybbler #(
    .SETUP_CYCLES      (S),
    .EPULSE_CYCLES     (P),
    .GAP_CYCLES        (G),
    .CMD_WAIT_CYCLES   (CMD),
    .CLEAR_WAIT_CYCLES (CLEAR),
    .ALIVE_BITS        (AB)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .bus      (bus.slave),
    .o_lcd_rs (lcd_rs),
    .o_lcd_rw (lcd_rw),
    .o_lcd_e  (lcd_e),
    .o_lcd_d  (lcd_d),
    .o_alive  (alive)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) alive_m <= 0;
    else     alive_m <= alive_m + 1;
  end

  function automatic logic alive_bit();
    return alive_m[AB-1];
  endfunction

  // Monitor one accepted write. Called at the negedge following the accepting
  // edge's preceding negedge (STB_I already high). Observed/expected packed as
  // {e, rs, rw, busy, stb, d[3:0], alive}.
  task automatic run_write(input string name, input logic [9:0] dat,
                           input int spur, input bit done_pulse);
    logic       rs, single;
    logic [3:0] hi, lo, exp_d;
    int         w, t_done, lo_start, e_pulses, stb_cnt;
    logic       exp_e, prev_e;
    logic [9:0] obs, exp;

    rs     = dat[9];
    single = dat[8];
    hi     = dat[7:4];
    lo     = dat[3:0];
    w      = (!rs && (dat[7:0] == 8'h01 || dat[7:0] == 8'h02 || dat[7:0] == 8'h03)) ? CLEAR : CMD;
    t_done = single ? (1 + S + P + w) : (1 + 2*S + 2*P + G + w);
    lo_start = 1 + S + P + G;
    e_pulses = 0;
    stb_cnt  = 0;
    prev_e   = 1'b0;

    for (int k = 1; k <= t_done + 1; k++) begin
      @(negedge clk);
      exp_e = (k >= 1 + S && k <= S + P) ||
              (!single && k >= lo_start + S && k <= lo_start + S + P - 1);
      exp_d = (!single && k >= lo_start) ? lo : hi;
      exp   = {exp_e, rs, 1'b0, (k <= t_done), (k == t_done), exp_d, alive_bit()};
      obs   = {lcd_e, lcd_rs, lcd_rw, bus.BUSY_O, bus.STB_O, lcd_d, alive};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d {e,rs,rw,busy,stb,d,alive} got %b want %b", name, k, obs, exp);
      end
      if (lcd_e && !prev_e) e_pulses++;
      prev_e = lcd_e;
      if (bus.STB_O) stb_cnt++;
      // Spurious requests while busy carry random data that must not be taken.
      bus.STB_I = (k == spur) || (done_pulse && k == t_done);
      if (bus.STB_I) bus.DAT_I = 10'($urandom);
    end

    checks++;
    if (e_pulses !== (single ? 1 : 2)) begin
      errors++;
      $display("FAIL %s e_pulses got %0d want %0d", name, e_pulses, single ? 1 : 2);
    end
    checks++;
    if (stb_cnt !== 1) begin
      errors++;
      $display("FAIL %s stb_count got %0d want 1", name, stb_cnt);
    end
    last_rs = rs;
    last_d  = single ? hi : lo;
  endtask

  task automatic do_write(input string name, input logic [9:0] dat,
                          input int spur, input bit done_pulse);
    bus.STB_I = 1'b1;
    bus.DAT_I = dat;
    run_write(name, dat, spur, done_pulse);
  endtask

  // Idle cycles with STB_I low: nothing may start, RS/DB keep their last values.
  task automatic idle(input string name, input int n);
    logic [9:0] obs, exp;
    bus.STB_I = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp = {1'b0, last_rs, 1'b0, 1'b0, 1'b0, last_d, alive_bit()};
      obs = {lcd_e, lcd_rs, lcd_rw, bus.BUSY_O, bus.STB_O, lcd_d, alive};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s idle%0d got %b want %b", name, k, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst       = 1'b1;
    bus.STB_I = 1'b1;
    bus.DAT_I = 10'h241;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {lcd_e, lcd_rs, lcd_rw, bus.BUSY_O, bus.STB_O, lcd_d, alive};
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL reset cyc%0d outputs got %b want %b", k, obs, 10'd0);
      end
      checks++;
      if (dut.r_alive !== 4'd0) begin
        errors++;
        $display("FAIL reset alive_cnt got %0d want 0", dut.r_alive);
      end
    end
    rst = 1'b0;
    // STB_I stays high: the first edge out of reset accepts the write.
    run_write("reset_accept", 10'h241, 0, 1'b0);
  endtask

  task automatic test_data_write();
    idle("data_pre", 3);
    do_write("data_A", 10'h241, 0, 1'b0);
    idle("data_post", 2);
  endtask

  task automatic test_commands();
    do_write("cmd_clear", 10'h001, 0, 1'b0);
    idle("cmd_clear_post", 2);
    do_write("cmd_home3", 10'h003, 0, 1'b0);
    idle("cmd_home_post", 2);
    do_write("cmd_28", 10'h028, 0, 1'b0);
    idle("cmd_28_post", 2);
    do_write("data_rs1_01", 10'h201, 0, 1'b0);
    idle("data_01_post", 2);
  endtask

  task automatic test_single_nibble();
    do_write("single_30", 10'h130, 0, 1'b0);
    idle("single_post", 4);
    do_write("single_clear", 10'h102, 0, 1'b0);
    idle("single_clear_post", 2);
  endtask

  task automatic test_ignored_strobes();
    do_write("ignore", 10'h2C5, 8, 1'b1);
    idle("ignore_post", 4);
  endtask

  task automatic test_back_to_back();
    do_write("b2b_0", 10'h248, 0, 1'b0);
    do_write("b2b_1", 10'h0C0, 0, 1'b0);
    do_write("b2b_2", 10'h130, 5, 1'b0);
    idle("b2b_post", 2);
  endtask

  task automatic test_random();
    logic [9:0] dat;
    for (int i = 0; i < 10; i++) begin
      dat = 10'($urandom);
      if ($urandom_range(0, 2) == 0) dat[7:0] = 8'($urandom_range(1, 3));
      do_write($sformatf("rand%0d", i), dat, $urandom_range(2, 14), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($sformatf("rand%0d_gap", i), $urandom_range(1, 3));
    end
    idle("rand_post", 2);
  endtask

  task automatic test_abort();
    logic [9:0] obs, exp;
    bus.STB_I = 1'b1;
    bus.DAT_I = 10'h028;
    for (int k = 1; k <= 1 + S + P + G + S; k++) begin
      @(negedge clk);
      bus.STB_I = 1'b0;
    end
    checks++;
    if (lcd_e !== 1'b1) begin
      errors++;
      $display("FAIL abort e_before got %b want 1", lcd_e);
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {lcd_e, lcd_rs, lcd_rw, bus.BUSY_O, bus.STB_O, lcd_d, alive};
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL abort outputs got %b want %b", obs, 10'd0);
    end
    checks++;
    if (dut.r_alive !== 4'd0) begin
      errors++;
      $display("FAIL abort alive_cnt got %0d want 0", dut.r_alive);
    end
    rst     = 1'b0;
    last_rs = 1'b0;
    last_d  = 4'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, alive_bit()};
      obs = {lcd_e, lcd_rs, lcd_rw, bus.BUSY_O, bus.STB_O, lcd_d, alive};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_after cyc%0d got %b want %b", k, obs, exp);
      end
    end
    checks++;
    if (dut.r_alive !== 4'(40)) begin
      errors++;
      $display("FAIL abort alive_restart got %0d want %0d", dut.r_alive, 4'(40));
    end
  endtask

  initial begin
    bus.STB_I = 1'b0;
    bus.DAT_I = 10'd0;
    test_reset();
    test_data_write();
    test_commands();
    test_single_nibble();
    test_ignored_strobes();
    test_back_to_back();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
